ireg_file: RTL and testbench
============================

# ireg_file

Architectural register file and write-back scoreboard for the ARM pipeline: the receiving end of the write-back stage's `write_data` / `reg_write_out` interface.
- Holds R0–R14, synthesises R15 reads from the PC, and serves two combinational read ports to decode.
- Tracks pending destination registers between decode issue and write-back, and asserts `stall` on RAW/WAW hazards.

## Interface
Parameters:
- `NUM_REGS`, 16, architectural register count; R15 is the PC.
- `PC_READ_OFFSET`, 8, added to `pc_in` on R15 reads.

Ports:
- `ir_clk`  in  1  pipeline clock; all state updates on the rising edge.
- `ir_rst`  in  1  reset, asynchronous, active-high.
- `rs1_addr`, `rs2_addr`  in  4  read-port register numbers.
- `rs1_data`, `rs2_data`  out  `WORD`  read data, combinational.
- `pc_in`  in  `WORD`  current PC, used for R15 reads.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_writes`  in  1  the issued instruction writes `issue_rd`.
- `issue_rd`  in  4  destination of the issued instruction.
- `stall`  out  1  issue rejected this cycle.
- `reg_write_in`  in  1  write-back strobe (driven by write-back `reg_write_out`).
- `write_addr`  in  4  write-back destination.
- `write_data`  in  `WORD`  write-back data.
- `busy_count`  out  5  number of pending writes.
- `wb_orphan`  out  1  sticky flag: a write-back arrived for a non-busy register.

## Operation
- **Register state:** `regs[0..14]` plus `busy[0..15]`.
- **Reads:**
  - `rsN_addr == 15` returns `pc_in + PC_READ_OFFSET`, modulo 2^32.
  - Otherwise returns `regs[rsN_addr]`, subject to bypass (see Configuration).
- **Write-back:** when `reg_write_in` is high, `regs[write_addr] <= write_data` and `busy[write_addr] <= 0`.
  - `write_addr == 15`: data is dropped and the busy bit is still cleared.
  - Write to a non-busy register: data is written, `busy_count` is unchanged, and `wb_orphan` sets until reset.
- **Hazard check:** `stall = issue_valid & (hz(rs1_addr) | hz(rs2_addr) | (issue_writes & hz(issue_rd)))`.
  - `hz(r) = busy_eff[r]`.
  - Reads of non-busy registers are never stalled.
- **Accept:** `issue_valid & ~stall & issue_writes` sets `busy[issue_rd]`.
- **Same-cycle set and clear of one register:** the set wins, so the bit ends at 1.
- **`busy_count`:**
  - +1 on accept-with-write.
  - −1 on a write-back that clears a busy bit.
  - Both in the same cycle: unchanged.
  - Never exceeds 16, because WAW stalls prevent double-marking.
  - Never wraps below 0; orphan write-backs do not decrement.
- **Reset:** asynchronous; `regs`, `busy`, `busy_count` and `wb_orphan` clear to 0.
  - `stall` is 0 whenever `issue_valid` is 0.
  - Read ports return 0, or `pc_in + 8` for R15.
  - Reset mid-operation discards all pending writes. Post-reset write-backs of those registers become orphans.

## Timing
- Reads: 0-cycle combinational.
- Write-back data is visible to reads on the cycle after the edge, or in the same cycle with bypass.
- `stall`: combinational from `issue_*`, `rs*_addr` and `busy`, plus write-back inputs when bypass is enabled.
- Busy set / clear and `busy_count` update on the edge at which accept or write-back is sampled.
- Load-use in the same register:
  - Without bypass: 1 extra stall cycle versus with bypass.

## Configuration
- **`IREG_FILE_BYPASS_EN` defined:**
  - A read matching `write_addr` while `reg_write_in` is high returns `write_data`, except for R15.
  - `busy_eff[r] = busy[r] & ~(reg_write_in & write_addr == r)`, so the stall releases in the write-back cycle.
- **Undefined:**
  - Reads return only registered `regs`.
  - `busy_eff = busy`, so the stall releases the cycle after write-back.

## Structure
- **`definitions.vh`:** gains `REG_ADDR_W` (4), `NUM_REGS` (16), `PC_REG` (15) and `PC_READ_OFFSET` (8), alongside the existing `WORD`.
- **Sub-module `reg_scoreboard`:** owns `busy[]`, `busy_count`, `wb_orphan` and the `stall` logic.
- **Top level:** `ireg_file` instantiates `reg_scoreboard` and holds the storage array plus read muxes.

## Test plan
1. **Reset:** assert `ir_rst` mid-cycle with a pending R3 → all outputs clear immediately; `rs1_addr=3` reads 0; `pc_in=0x100`, `rs2_addr=15` reads `0x108`.
2. **Issue then write-back:** issue R4 write → `busy_count=1`; `rs1_addr=4` issue stalls; write-back R4=`0xDEADBEEF` → stall releases (same cycle with bypass, next cycle without) and R4 reads `0xDEADBEEF`; `busy_count=0`.
3. **Simultaneous set and clear:** accepted issue writing R5 in the same cycle as write-back of R5 → `busy[5]=1`, `busy_count` unchanged.
4. **WAW:** R6 busy, issue with `issue_rd=6` → `stall=1`, `busy_count` unchanged.
5. **Orphan:** write-back R7 with no pending issue → R7 updated, `wb_orphan=1` and sticky, `busy_count=0`.
6. **R15 write-back:** write-back to R15 with `0x1234` → busy clears; R15 still reads `pc_in + 8`.

Source files
------------

// File: rtl/ireg_file_pkg.sv
// rtl/ireg_file_pkg.sv - shared widths and constants for ireg_file (IREG_FILE_BYPASS_EN selects write-back bypass)
package ireg_file_pkg;
    localparam int WORD               = 32;
    localparam int REG_ADDR_W         = 4;
    localparam int DEF_NUM_REGS       = 16;
    localparam int DEF_PC_READ_OFFSET = 8;
    localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;
`ifdef IREG_FILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif
endpackage

// File: rtl/ireg_file_scoreboard.sv
// rtl/ireg_file_scoreboard.sv - pending-write scoreboard with RAW/WAW stall (IREG_FILE_BYPASS_EN releases stall in write-back cycle)
module reg_scoreboard
    import ireg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                  ir_clk,
    input  logic                  ir_rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] write_addr,
    output logic                  stall,
    output logic [4:0]            busy_count,
    output logic                  wb_orphan
);
    logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff, wb_vec, set_vec;
    logic [4:0]          busy_count_q, busy_count_d;
    logic                wb_orphan_q, wb_orphan_d;
    logic                accept, clr_hit;

    always_comb begin
        wb_vec   = reg_write_in ? (NUM_REGS'(1) << write_addr) : '0;
        busy_eff = BYPASS_EN ? (busy_q & ~wb_vec) : busy_q;
        stall    = issue_valid & (busy_eff[rs1_addr] | busy_eff[rs2_addr]
                                  | (issue_writes & busy_eff[issue_rd]));
        accept   = issue_valid & ~stall & issue_writes;
        set_vec  = accept ? (NUM_REGS'(1) << issue_rd) : '0;
        clr_hit  = reg_write_in & busy_q[write_addr];
        // Clear first, then set, so a same-cycle set of the same register wins.
        busy_d       = (busy_q & ~wb_vec) | set_vec;
        busy_count_d = busy_count_q + {4'b0, accept} - {4'b0, clr_hit};
        wb_orphan_d  = wb_orphan_q | (reg_write_in & ~busy_q[write_addr]);
    end

    always_ff @(posedge ir_clk or posedge ir_rst) begin
        if (ir_rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            wb_orphan_q  <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            wb_orphan_q  <= wb_orphan_d;
        end
    end

    assign busy_count = busy_count_q;
    assign wb_orphan  = wb_orphan_q;
endmodule

// File: rtl/ireg_file.sv
// rtl/ireg_file.sv - architectural register file R0-R14 with PC-synthesised R15 (IREG_FILE_BYPASS_EN forwards write_data to reads)
module ireg_file
    import ireg_file_pkg::*;
#(
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int PC_READ_OFFSET = DEF_PC_READ_OFFSET
) (
    input  logic                  ir_clk,
    input  logic                  ir_rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [WORD-1:0]       rs1_data,
    output logic [WORD-1:0]       rs2_data,
    input  logic [WORD-1:0]       pc_in,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  stall,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] write_addr,
    input  logic [WORD-1:0]       write_data,
    output logic [4:0]            busy_count,
    output logic                  wb_orphan
);
    logic [WORD-1:0] regs_q [NUM_REGS-1];
    logic [WORD-1:0] regs_d [NUM_REGS-1];

    function automatic logic [WORD-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        if (addr == PC_REG)
            return pc_in + WORD'(PC_READ_OFFSET);
        else if (BYPASS_EN && reg_write_in && write_addr == addr)
            return write_data;
        else
            return regs_q[addr];
    endfunction

    always_comb begin
        regs_d = regs_q;
        // R15 has no storage; its write-back only clears the scoreboard bit.
        if (reg_write_in && write_addr != PC_REG)
            regs_d[write_addr] = write_data;
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge ir_clk or posedge ir_rst) begin
        if (ir_rst) begin
            for (int i = 0; i < NUM_REGS - 1; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .ir_clk       (ir_clk),
        .ir_rst       (ir_rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .issue_valid  (issue_valid),
        .issue_writes (issue_writes),
        .issue_rd     (issue_rd),
        .reg_write_in (reg_write_in),
        .write_addr   (write_addr),
        .stall        (stall),
        .busy_count   (busy_count),
        .wb_orphan    (wb_orphan)
    );
endmodule

// File: tb/tb_ireg_file.sv
// tb/tb_ireg_file.sv - directed plus randomized checks of ireg_file against a pending-set reference model
module tb_ireg_file;
    logic        ir_clk = 1'b0;
    logic        ir_rst = 1'b1;
    logic [3:0]  rs1_addr = '0, rs2_addr = '0, issue_rd = '0, write_addr = '0;
    logic [31:0] rs1_data, rs2_data, write_data = '0, pc_in = '0;
    logic        issue_valid = 1'b0, issue_writes = 1'b0, reg_write_in = 1'b0;
    logic        stall, wb_orphan;
    logic [4:0]  busy_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [15];
    bit          m_pending [16];
    bit          m_orphan;
    localparam bit BYP = ireg_file_pkg::BYPASS_EN;

    always #5 ir_clk = ~ir_clk;

    ireg_file dut (
        .ir_clk(ir_clk), .ir_rst(ir_rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc_in(pc_in),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_rd(issue_rd),
        .stall(stall),
        .reg_write_in(reg_write_in), .write_addr(write_addr), .write_data(write_data),
        .busy_count(busy_count), .wb_orphan(wb_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        for (int i = 0; i < 16; i++) m_pending[i] = 1'b0;
        m_orphan = 1'b0;
    endtask

    function automatic int pending_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pending[i]);
        return n;
    endfunction

    function automatic bit hazard(input logic [3:0] r);
        return m_pending[r] && !(BYP && reg_write_in && write_addr == r);
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] r);
        if (r == 4'd15) return pc_in + 32'd8;
        if (BYP && reg_write_in && write_addr == r) return write_data;
        return m_regs[r];
    endfunction

    // Drive one cycle of stimulus, check combinational and state outputs, then advance the model.
    task automatic step(input logic iv, input logic iw, input logic [3:0] rd,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic wb, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [31:0] pc);
        bit exp_stall;
        issue_valid = iv; issue_writes = iw; issue_rd = rd;
        rs1_addr = r1; rs2_addr = r2;
        reg_write_in = wb; write_addr = wa; write_data = wd; pc_in = pc;
        #1;
        exp_stall = iv && (hazard(r1) || hazard(r2) || (iw && hazard(rd)));
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("rs1_data", rs1_data, exp_read(r1));
        chk("rs2_data", rs2_data, exp_read(r2));
        chk("busy_count", {27'b0, busy_count}, 32'(pending_count()));
        chk("wb_orphan", {31'b0, wb_orphan}, {31'b0, m_orphan});
        @(posedge ir_clk);
        if (wb) begin
            if (!m_pending[wa]) m_orphan = 1'b1;
            m_pending[wa] = 1'b0;
            if (wa != 4'd15) m_regs[wa] = wd;
        end
        if (iv && !exp_stall && iw) m_pending[rd] = 1'b1;
        @(negedge ir_clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h100);
    endtask

    initial begin
        logic [3:0]  wa, r1, r2, rd;
        model_reset();
        repeat (2) @(negedge ir_clk);
        ir_rst = 1'b0;

        // Reset: a pending R3 with data is wiped mid-cycle.
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 32'h0000_00AA, 32'h100);
        step(1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h100);
        chk("rst_pre_count", {27'b0, busy_count}, 32'd1);
        issue_valid = 1'b1; issue_writes = 1'b0; rs1_addr = 4'd3; rs2_addr = 4'd15;
        pc_in = 32'h100; reg_write_in = 1'b0;
        #2 ir_rst = 1'b1;
        #1;
        chk("rst_count", {27'b0, busy_count}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_r3", rs1_data, 32'd0);
        chk("rst_r15", rs2_data, 32'h108);
        model_reset();
        @(negedge ir_clk);
        ir_rst = 1'b0;

        // Issue R4 then write-back 0xDEADBEEF; a reader of R4 stalls until released.
        step(1'b1, 1'b1, 4'd4, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0, 32'h200);
        chk("t2_count", {27'b0, busy_count}, 32'd1);
        step(1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 1'b0, 4'd0, 32'd0, 32'h200);
        step(1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 1'b1, 4'd4, 32'hDEAD_BEEF, 32'h200);
        step(1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 1'b0, 4'd0, 32'd0, 32'h200);
        chk("t2_r4", rs1_data, 32'hDEAD_BEEF);
        chk("t2_count0", {27'b0, busy_count}, 32'd0);

        // Same-cycle issue and write-back of R5 (with R5 previously pending).
        step(1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h300);
        step(1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b1, 4'd5, 32'h5555_5555, 32'h300);
        step(1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 1'b0, 4'd0, 32'd0, 32'h300);
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 32'h6666_6666, 32'h300);

        // WAW on R6.
        step(1'b1, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h400);
        step(1'b1, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h400);
        chk("t4_count", {27'b0, busy_count}, 32'd1);
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd6, 32'h0606_0606, 32'h400);

        // Orphan write-back of R7; flag must stay set.
        step(1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 1'b1, 4'd7, 32'h7777_0007, 32'h500);
        idle();
        idle();
        chk("t5_orphan", {31'b0, wb_orphan}, 32'd1);

        // R15 write-back clears its busy bit but stores nothing.
        step(1'b1, 1'b1, 4'd15, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h600);
        step(1'b0, 1'b0, 4'd0, 4'd15, 4'd15, 1'b1, 4'd15, 32'h1234, 32'h600);
        step(1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 1'b0, 4'd0, 32'd0, 32'h600);
        chk("t6_r15", rs1_data, 32'h608);
        chk("t6_count", {27'b0, busy_count}, 32'd0);

        // Randomized traffic: write-backs lean toward pending registers.
        for (int n = 0; n < 400; n++) begin
            wa = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                for (int k = 0; k < 16; k++)
                    if (m_pending[k] && $urandom_range(0, 2) == 0) wa = 4'(k);
            r1 = 4'($urandom_range(0, 15));
            r2 = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, r1, r2,
                 ($urandom_range(0, 2) == 0), wa, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
